// File: rtl/data_mem_ctrl_if.sv
// MEM-stage data memory bus: pipeline access, halt request and image dump port.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              MemWriteM;
    logic [1:0]        MemSizeM;
    logic              MemSignedM;
    logic [31:0]       ALUOutM;
    logic [31:0]       WD;
    logic              StopM;
    logic              DumpReady;
    logic [31:0]       ReadDataM;
    logic              AlignErrM;
    logic              RangeErrM;
    logic              BusyM;
    logic              DumpValid;
    logic [ADDR_W-1:0] DumpAddr;
    logic [31:0]       DumpData;
    logic              DumpDone;

    modport master (
        output MemWriteM, MemSizeM, MemSignedM, ALUOutM, WD, StopM, DumpReady,
        input  ReadDataM, AlignErrM, RangeErrM, BusyM, DumpValid, DumpAddr, DumpData, DumpDone
    );

    modport slave (
        input  MemWriteM, MemSizeM, MemSignedM, ALUOutM, WD, StopM, DumpReady,
        output ReadDataM, AlignErrM, RangeErrM, BusyM, DumpValid, DumpAddr, DumpData, DumpDone
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable MIPS32 data memory with post-reset clear sweep and halt-time dump.
// All state advances on the falling edge so results meet the W-stage rising-edge latch.
module data_mem_ctrl #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input logic            CLK,
    input logic            RST,
    data_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {CLEAR, IDLE, DUMP, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic              stop_pend, stop_pend_nx;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word;
    logic              range_err, align_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_val;
    logic [3:0]        be;
    logic [31:0]       lane, st_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [31:0]       mem_wd;
    logic [31:0]       rd_nx;
    logic              al_nx, rg_nx;

    assign idx      = bus.ALUOutM[ADDR_W+1:2];
    assign old_word = mem[idx];

    // Address checks, load extraction and store lane merge (load sees pre-store data).
    always_comb begin
        range_err = |bus.ALUOutM[31:ADDR_W+2];
        case (bus.MemSizeM)
            2'b00:   align_err = 1'b0;
            2'b01:   align_err = bus.ALUOutM[0];
            2'b10:   align_err = |bus.ALUOutM[1:0];
            default: align_err = 1'b1;
        endcase

        ld_byte = old_word[{bus.ALUOutM[1:0], 3'b000} +: 8];
        ld_half = bus.ALUOutM[1] ? old_word[31:16] : old_word[15:0];
        case (bus.MemSizeM)
            2'b00:   load_val = {{24{bus.MemSignedM & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{16{bus.MemSignedM & ld_half[15]}}, ld_half};
            default: load_val = old_word;
        endcase

        case (bus.MemSizeM)
            2'b00: begin
                be   = 4'b0001 << bus.ALUOutM[1:0];
                lane = {4{bus.WD[7:0]}};
            end
            2'b01: begin
                be   = bus.ALUOutM[1] ? 4'b1100 : 4'b0011;
                lane = {2{bus.WD[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                lane = bus.WD;
            end
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            st_word[8*i +: 8] = be[i] ? lane[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state     <= CLEAR;
            ptr       <= '0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            stop_pend <= stop_pend_nx;
        end
    end

    // One pointer serves both the clear sweep and the dump walk.
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        stop_pend_nx = stop_pend;
        case (state)
            CLEAR: begin
                ptr_nx = ptr + ADDR_W'(1);
                if (bus.StopM) stop_pend_nx = 1'b1;
                if (ptr == LAST) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                end
            end
            IDLE: begin
                if (bus.StopM || stop_pend) begin
                    state_nx     = DUMP;
                    ptr_nx       = '0;
                    stop_pend_nx = 1'b0;
                end
            end
            DUMP: begin
                if (bus.DumpReady) begin
                    ptr_nx = ptr + ADDR_W'(1);
                    if (ptr == LAST) state_nx = DONE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = idx;
        mem_wd = st_word;
        rd_nx  = '0;
        al_nx  = 1'b0;
        rg_nx  = 1'b0;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = ptr;
                mem_wd = '0;
            end
            IDLE: begin
                al_nx = align_err;
                rg_nx = range_err;
                if (!align_err && !range_err) begin
                    rd_nx  = load_val;
                    mem_we = bus.MemWriteM;
                end
            end
            default: ;
        endcase

        bus.BusyM     = (state != IDLE);
        bus.DumpValid = (state == DUMP);
        bus.DumpDone  = (state == DONE);
        bus.DumpAddr  = (state == DUMP) ? ptr : '0;
        bus.DumpData  = (state == DUMP) ? mem[ptr] : '0;
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            bus.ReadDataM <= '0;
            bus.AlignErrM <= 1'b0;
            bus.RangeErrM <= 1'b0;
        end else begin
            bus.ReadDataM <= rd_nx;
            bus.AlignErrM <= al_nx;
            bus.RangeErrM <= rg_nx;
        end
    end

    always_ff @(negedge CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data memory for the MEM stage of the 5-stage MIPS32 pipeline. Successor to the fixed 512-word, word-only data RAM.
- Adds byte/halfword/word stores and loads with sign/zero extension.
- Flags misaligned and out-of-range accesses.
- Performs a hardware clear sweep after reset.
- On halt, streams the full memory image out through a valid/ready dump port for the bench to write to file.

Parameters:
DEPTH, 512, number of 32-bit words; must be a power of two ≥ 4.
ADDR_W, 9, log2(DEPTH); width of the word index and of DumpAddr.

Ports:
CLK  in  1  pipeline clock; all state updates on the falling edge.
RST  in  1  asynchronous, active-high reset.
MemWriteM  in  1  store enable.
MemSizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
MemSignedM  in  1  1 = sign-extend sub-word loads; 0 = zero-extend.
ALUOutM  in  32  byte address.
WD  in  32  store data; sub-word data is taken from the low bits.
StopM  in  1  halt request; starts the dump.
DumpReady  in  1  consumer ready for the dump word.
ReadDataM  out  32  load result, extended.
AlignErrM  out  1  registered misalignment flag for the current access.
RangeErrM  out  1  registered out-of-range flag for the current access.
BusyM  out  1  high in CLEAR, DUMP and DONE.
DumpValid  out  1  dump word valid.
DumpAddr  out  ADDR_W  word index of DumpData.
DumpData  out  32  memory word at DumpAddr.
DumpDone  out  1  full image transferred; sticky until reset.

Behaviour:
- Reset (async, RST=1):
  - state=CLEAR, clear pointer=0.
  - ReadDataM=0, AlignErrM=0, RangeErrM=0, BusyM=1.
  - DumpValid=0, DumpAddr=0, DumpData=0, DumpDone=0.
  - Stop-pending flag cleared.
  - Release is seen at the next falling edge.
- Timing: outputs register on the falling edge of CLK, so MEM-stage results are ready for the W-stage rising-edge latch in the same cycle. The store and the load of the same address on the same edge return OLD data, i.e. read-before-write.
- FSM states: CLEAR, IDLE, DUMP, DONE.
  - CLEAR: one word is zeroed per edge at the pointer, then the pointer increments. After writing DEPTH-1 the FSM goes to IDLE; clearing takes DEPTH edges. Accesses are ignored: no write, ReadDataM=0, error flags 0. StopM=1 sets stop-pending.
  - IDLE: normal accesses. StopM=1 or stop-pending moves to DUMP with pointer=0, and the access on that edge is still performed.
  - DUMP: DumpValid=1, DumpAddr=pointer, DumpData=RAM[pointer]. A transfer happens on an edge where DumpReady=1; the pointer then increments. While DumpReady=0, DumpAddr and DumpData hold stable. After the transfer of word DEPTH-1, DumpValid drops to 0 and the FSM goes to DONE. Memory accesses are ignored.
  - DONE: DumpDone=1; the FSM stays here until reset. StopM is ignored.
- Addressing:
  - Word index = ALUOutM[31:2].
  - RangeErr when ALUOutM[31:2] ≥ DEPTH, i.e. any bit of ALUOutM[31:ADDR_W+2] is set.
  - AlignErr when any of:
    - half access with ALUOutM[0]=1;
    - word access with ALUOutM[1:0]≠0;
    - size=11.
- On any error: no write occurs, ReadDataM=0, and the flag is registered on that edge whether or not it is a store. When both errors apply, both flags are 1.
- Byte lanes are little-endian:
  - Byte k = bits 8k+7:8k, selected by ALUOutM[1:0].
  - Half h = bits 16h+15:16h, selected by ALUOutM[1].
  - Stores modify only the addressed lanes; other bytes are preserved.
- Loads:
  - Byte/half are extended per MemSignedM.
  - Word is passed unchanged; MemSignedM is ignored.
  - ReadDataM updates on every IDLE edge, including store edges, where it returns the old data.
- Reset mid-DUMP or mid-CLEAR aborts the operation and restarts CLEAR. Memory contents are then undefined until CLEAR completes.

Test Plan:
1. Reset → BusyM=1 for 512 falling edges, then 0. A word load at address 0x1FC → ReadDataM=0x00000000.
2. Word store 0x11223344 at 0x10. Then:
   - byte store 0xAB at 0x12;
   - signed byte load at 0x12 → 0xFFFFFFAB;
   - unsigned half load at 0x12 → 0x000011AB;
   - word load at 0x10 → 0x11AB3344.
3. Word store at 0x13 → AlignErrM=1, no write; the word at 0x10 is unchanged. Half load at 0x11 → AlignErrM=1, ReadDataM=0. Word store at 0x800 → RangeErrM=1, no write (DEPTH=512).
4. Same-edge store 0x5 at 0x20 whose load reads 0x20 (prior value 0) → ReadDataM=0. A load on the next edge → 0x5.
5. Pulse StopM with DumpReady toggling 1,0,0,1,...:
   - DumpAddr increments only on ready edges; DumpData holds while stalled;
   - exactly 512 transfers, the word at index 4 = 0x11AB3344;
   - then DumpDone=1 and DumpValid=0.
6. StopM during CLEAR → dump starts right after CLEAR ends. RST asserted mid-DUMP → DumpValid=0 and BusyM=1 at once, and CLEAR restarts.
